// File: rtl/wm_pkg.sv
// Shared washing-machine definitions: controller state encoding, phase one-hot indices
// and small helpers reused by the phase controller and its timer.
package wm_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFill,
      StHeat,
      StRun,
      StDrain,
      StDone,
      StFault
   } state_e;

   localparam int unsigned NumPhases  = 4;
   localparam int unsigned PhaseSoak  = 0;
   localparam int unsigned PhaseWash  = 1;
   localparam int unsigned PhaseRinse = 2;
   localparam int unsigned PhaseSpin  = 3;

   typedef logic [NumPhases-1:0] phase_t;

   // Zero or exactly one request bit set.
   function automatic logic phase_legal(phase_t v);
      return (v & (v - phase_t'(1))) == '0;
   endfunction

   // A zero-length phase still waits for one tick.
   function automatic int unsigned eff_ticks(int unsigned n);
      return (n == 0) ? 1 : n;
   endfunction

endpackage

// File: rtl/phase_timer_if.sv
// Controller-side signal bundle for phase_timer: phase requests, time base and lid in,
// completion pulses, actuator drives and fault out.
interface phase_timer_if;
   logic tick;
   logic soak_Operation;
   logic wash_Operation;
   logic rinse_Operation;
   logic spin_Operation;
   logic lid;
   logic fill_Water;
   logic heat_Water;
   logic wash;
   logic valve_On;
   logic heater_On;
   logic motor_On;
   logic motor_Fast;
   logic drain_On;
   logic fault;

   modport master (
      output tick, soak_Operation, wash_Operation, rinse_Operation, spin_Operation, lid,
      input  fill_Water, heat_Water, wash, valve_On, heater_On, motor_On, motor_Fast,
             drain_On, fault
   );

   modport slave (
      input  tick, soak_Operation, wash_Operation, rinse_Operation, spin_Operation, lid,
      output fill_Water, heat_Water, wash, valve_On, heater_On, motor_On, motor_Fast,
             drain_On, fault
   );
endinterface

// File: rtl/tick_counter.sv
// Saturating tick counter with synchronous clear, freeze and a terminal-count compare
// against the current phase length.
module tick_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             enable,
   input  logic             freeze,
   input  logic [CNT_W-1:0] target,
   output logic             done
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !freeze && (count_q != CntMax)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q >= target);

endmodule

// File: rtl/phase_timer.sv
// Wash-cycle phase sequencer: steps FILL/HEAT/RUN or DRAIN on a tick time base, drives the
// actuators, and drops to IDLE or FAULT when the request vector changes or becomes illegal.
module phase_timer
   import wm_pkg::*;
#(
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned FILL_TICKS  = 20,
   parameter int unsigned HEAT_TICKS  = 30,
   parameter int unsigned SOAK_TICKS  = 60,
   parameter int unsigned WASH_TICKS  = 90,
   parameter int unsigned RINSE_TICKS = 40,
   parameter int unsigned SPIN_TICKS  = 50
) (
   input  logic          clock,
   input  logic          reset_n,
   phase_timer_if.slave  bus
);

   localparam longint unsigned CntMax = (64'd1 << CNT_W) - 64'd1;

   if ((FILL_TICKS > CntMax) || (HEAT_TICKS > CntMax) || (SOAK_TICKS > CntMax) ||
       (WASH_TICKS > CntMax) || (RINSE_TICKS > CntMax) || (SPIN_TICKS > CntMax))
   begin : g_param_check
      $error("phase_timer: a tick parameter exceeds the counter range");
   end

   localparam logic [CNT_W-1:0] FillTgt  = CNT_W'(eff_ticks(FILL_TICKS));
   localparam logic [CNT_W-1:0] HeatTgt  = CNT_W'(eff_ticks(HEAT_TICKS));
   localparam logic [CNT_W-1:0] SoakTgt  = CNT_W'(eff_ticks(SOAK_TICKS));
   localparam logic [CNT_W-1:0] WashTgt  = CNT_W'(eff_ticks(WASH_TICKS));
   localparam logic [CNT_W-1:0] RinseTgt = CNT_W'(eff_ticks(RINSE_TICKS));
   localparam logic [CNT_W-1:0] SpinTgt  = CNT_W'(eff_ticks(SPIN_TICKS));

   state_e           state_q, state_d;
   phase_t           phase_q, phase_d;
   phase_t           vec;
   logic             fill_p, heat_p;
   logic [CNT_W-1:0] target;
   logic             tc_done, freeze, clear;

   always_comb begin
      vec             = '0;
      vec[PhaseSoak]  = bus.soak_Operation;
      vec[PhaseWash]  = bus.wash_Operation;
      vec[PhaseRinse] = bus.rinse_Operation;
      vec[PhaseSpin]  = bus.spin_Operation;
   end

   always_comb begin
      target = '1;
      case (state_q)
         StFill:  target = FillTgt;
         StHeat:  target = HeatTgt;
         StRun: begin
            if (phase_q[PhaseSoak])      target = SoakTgt;
            else if (phase_q[PhaseWash]) target = WashTgt;
            else                         target = RinseTgt;
         end
         StDrain: target = SpinTgt;
         default: target = '1;
      endcase
   end

   // Illegal requests win over everything; any other change of request aborts a running cycle.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      fill_p  = 1'b0;
      heat_p  = 1'b0;
      if ((state_q != StFault) && !phase_legal(vec)) begin
         state_d = StFault;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (vec != '0) begin
                  phase_d = vec;
                  state_d = vec[PhaseSpin] ? StDrain : StFill;
               end
            end
            StFill: begin
               if (vec != phase_q) begin
                  state_d = StIdle;
               end else if (tc_done) begin
                  fill_p  = 1'b1;
                  state_d = phase_q[PhaseRinse] ? StRun : StHeat;
               end
            end
            StHeat: begin
               if (vec != phase_q) begin
                  state_d = StIdle;
               end else if (tc_done) begin
                  heat_p  = 1'b1;
                  state_d = StRun;
               end
            end
            StRun, StDrain: begin
               if (vec != phase_q)  state_d = StIdle;
               else if (tc_done)    state_d = StDone;
            end
            StDone: begin
               if (vec != phase_q) state_d = StIdle;
            end
            StFault: begin
               if (vec == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
      if (state_d == StIdle) phase_d = '0;
   end

   assign clear  = (state_d != state_q);
   assign freeze = bus.lid && ((state_q == StRun) || (state_q == StDrain));

   tick_counter #(
      .CNT_W (CNT_W)
   ) u_tick_counter (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (clear),
      .enable  (bus.tick),
      .freeze  (freeze),
      .target  (target),
      .done    (tc_done)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= StIdle;
         phase_q        <= '0;
         bus.fill_Water <= 1'b0;
         bus.heat_Water <= 1'b0;
         bus.wash       <= 1'b0;
         bus.valve_On   <= 1'b0;
         bus.heater_On  <= 1'b0;
         bus.motor_On   <= 1'b0;
         bus.motor_Fast <= 1'b0;
         bus.drain_On   <= 1'b0;
         bus.fault      <= 1'b0;
      end else begin
         state_q        <= state_d;
         phase_q        <= phase_d;
         bus.fill_Water <= fill_p;
         bus.heat_Water <= heat_p;
         bus.wash       <= (state_d == StDone) && (state_q != StDone);
         bus.valve_On   <= (state_d == StFill);
         bus.heater_On  <= (state_d == StHeat);
         bus.motor_On   <= ((state_d == StRun) || (state_d == StDrain)) && !bus.lid;
         bus.motor_Fast <= (state_d == StDrain) && !bus.lid;
         bus.drain_On   <= (state_d == StDrain);
         bus.fault      <= (state_d == StFault);
      end
   end

endmodule

// File: doc/phase_timer.md
PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 Parameter CNT_W, 8, width of the tick counter.
REQ-002 Parameter FILL_TICKS, 20, ticks spent in FILL.
REQ-003 Parameter HEAT_TICKS, 30, ticks spent in HEAT.
REQ-004 Parameter SOAK_TICKS / WASH_TICKS / RINSE_TICKS / SPIN_TICKS, 60/90/40/50, RUN length per phase.
REQ-005 Port clock  in  1  single clock, all logic on rising edge.
REQ-006 Port reset_n  in  1  asynchronous active-low reset.
REQ-007 Port tick  in  1  one-cycle time-base enable (1 Hz nominal).
REQ-008 Port soak_Operation / wash_Operation / rinse_Operation / spin_Operation  in  1 each  phase request from controller, level.
REQ-009 Port lid  in  1  1 = lid open.
REQ-010 Port fill_Water  out  1  one-cycle pulse, fill complete.
REQ-011 Port heat_Water  out  1  one-cycle pulse, heat complete.
REQ-012 Port wash  out  1  one-cycle pulse, phase complete.
REQ-013 Port valve_On / heater_On / motor_On / motor_Fast / drain_On  out  1 each  actuator drives, level.
REQ-014 Port fault  out  1  sticky, illegal phase request.

Function
REQ-015 States SHALL be IDLE, FILL, HEAT, RUN, DRAIN, DONE, FAULT.
REQ-016 Phase vector SHALL be the four operation inputs; legal = zero or exactly one bit set.
REQ-017 IDLE: on a legal one-hot vector, soak/wash/rinse SHALL go to FILL, spin SHALL go to DRAIN; counter cleared on entry to every state.
REQ-018 Counter SHALL increment only on cycles with tick=1; a state of N ticks SHALL exit on the cycle after the Nth tick is counted; N=0 SHALL behave as N=1.
REQ-019 FILL: valve_On=1; at exit fill_Water pulses once; soak/wash go to HEAT, rinse goes to RUN.
REQ-020 HEAT: heater_On=1; at exit heat_Water pulses once; go to RUN.
REQ-021 RUN: motor_On=1 for SOAK_TICKS/WASH_TICKS/RINSE_TICKS per latched phase; go to DONE.
REQ-022 DRAIN (spin only): drain_On=1, motor_On=1, motor_Fast=1 for SPIN_TICKS; go to DONE.
REQ-023 lid=1 in RUN or DRAIN SHALL freeze the counter and force motor_On=motor_Fast=0; counting resumes when lid=0, no count lost or repeated.
REQ-024 Entering DONE SHALL pulse wash for exactly one cycle; DONE SHALL hold, all actuators off, until the phase vector changes, then return to IDLE.
REQ-025 Phase latched at leave-IDLE; if the vector differs from the latched one in FILL/HEAT/RUN/DRAIN, next cycle SHALL be IDLE, actuators off, no pulses.
REQ-026 An illegal vector (2+ bits) in any non-FAULT state SHALL enter FAULT next cycle: fault=1, actuators off; FAULT exits to IDLE only when vector is all-zero, fault cleared on that exit.
REQ-027 Counter SHALL saturate at 2^CNT_W-1; parameters exceeding that are an elaboration error.
REQ-028 All outputs SHALL be registered; pulse outputs never high two consecutive cycles.

Reset
REQ-029 reset_n=0 SHALL immediately force state IDLE, counter 0, latched phase 0, every output 0.
REQ-030 Reset released mid-operation SHALL resume from IDLE; an asserted phase restarts from FILL/DRAIN.

Structure
REQ-031 State encoding and phase one-hot index constants SHALL live in shared package wm_pkg, reused by the controller.
REQ-032 One sub-module, tick_counter (clear, enable, freeze, terminal-count compare), is natural; remainder is one FSM.

Verification
REQ-033 wash_Operation=1, tick every 4 clocks, FILL=2/HEAT=3/WASH=4 -> fill_Water after 2nd tick, heat_Water after 5th, wash pulse after 9th, actuators sequenced valve/heater/motor.
REQ-034 spin_Operation=1, SPIN=3, lid=1 for 5 ticks mid-DRAIN -> motor off while open, wash pulses after 3 counted ticks total.
REQ-035 rinse then wash_Operation+rinse_Operation both 1 in FILL -> fault=1 next cycle, cleared only after vector 0.
REQ-036 soak_Operation dropped mid-HEAT -> IDLE next cycle, no heat_Water/wash pulse.
REQ-037 reset_n=0 asynchronously mid-RUN -> all outputs 0 before next edge; release with soak held -> FILL restarts, counter 0.
REQ-038 Phase held in DONE for 10 cycles -> single wash pulse only.
